// File: rtl/wbm_serial_bridge.sv
// Byte-serial command bridge ('R'/'W' + address/data bytes) to a 16-bit Wishbone master.
// Define WBM_SERIAL_TIMEOUT_EN to abort bus cycles after TOUT cycles without ack.
//
// state | meaning
// IDLE  | waiting for command byte
// ADRL  | waiting for address low byte
// ADRH  | waiting for address high byte
// DATL  | waiting for write data low byte
// DATH  | waiting for write data high byte
// BUS   | Wishbone cycle in progress
// RSP0  | first response byte pending
// RSP1  | read data low byte pending
// RSP2  | read data high byte pending
// GAP   | one idle cycle after each transmitted byte
module wbm_serial_bridge #(
   parameter int unsigned TOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic [7:0]  rx_dat_i,
   input  logic        rx_stb_i,
   output logic [7:0]  tx_dat_o,
   output logic        tx_stb_o,
   input  logic        tx_rdy_i,
   output logic [15:0] wb_adr_o,
   output logic [15:0] wb_dat_o,
   input  logic [15:0] wb_dat_i,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   input  logic        wb_ack_i,
   output logic        busy_o
);

   typedef enum logic [3:0] {
      IDLE, ADRL, ADRH, DATL, DATH, BUS, RSP0, RSP1, RSP2, GAP
   } state_t;

   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] RSP_OK  = 8'h2B;
   localparam logic [7:0] RSP_BAD = 8'h3F;
   localparam logic [7:0] RSP_TO  = 8'h21;

   state_t      state_q, state_d, ret_q, ret_d;
   logic        arm_q;
   logic        wr_q;
   logic        multi_q;
   logic [7:0]  rsp_q;
   logic [15:0] rdat_q;
   logic        rx_ok, is_cmd;
   logic        tx_fire, bus_done, bus_tout, bus_start, tout_hit;
   logic [7:0]  tx_byte;

   // arm_q keeps the first edge after reset release from consuming a stale strobe
   assign rx_ok     = rx_stb_i && arm_q;
   assign is_cmd    = (rx_dat_i == CMD_RD) || (rx_dat_i == CMD_WR);
   assign bus_start = (state_q == BUS) && !wb_cyc_o;
   assign busy_o    = (state_q != IDLE);

`ifdef WBM_SERIAL_TIMEOUT_EN
   logic [15:0] tout_cnt;

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i)
         tout_cnt <= 16'h0000;
      else if (state_q != BUS)
         tout_cnt <= 16'h0000;
      else
         tout_cnt <= tout_cnt + 16'h0001;
   end

   assign tout_hit = wb_cyc_o && (tout_cnt == 16'(TOUT));
`else
   assign tout_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      tx_fire  = 1'b0;
      tx_byte  = 8'h00;
      bus_done = 1'b0;
      bus_tout = 1'b0;
      case (state_q)
         IDLE: if (rx_ok) state_d = is_cmd ? ADRL : RSP0;
         ADRL: if (rx_ok) state_d = ADRH;
         ADRH: if (rx_ok) state_d = wr_q ? DATL : BUS;
         DATL: if (rx_ok) state_d = DATH;
         DATH: if (rx_ok) state_d = BUS;
         BUS: begin
            // ack wins over a timeout landing on the same cycle
            if (wb_cyc_o && wb_ack_i) begin
               bus_done = 1'b1;
               state_d  = RSP0;
            end else if (tout_hit) begin
               bus_tout = 1'b1;
               state_d  = RSP0;
            end
         end
         RSP0: if (tx_rdy_i) begin
            tx_fire = 1'b1;
            tx_byte = rsp_q;
            ret_d   = multi_q ? RSP1 : IDLE;
            state_d = GAP;
         end
         RSP1: if (tx_rdy_i) begin
            tx_fire = 1'b1;
            tx_byte = rdat_q[7:0];
            ret_d   = RSP2;
            state_d = GAP;
         end
         RSP2: if (tx_rdy_i) begin
            tx_fire = 1'b1;
            tx_byte = rdat_q[15:8];
            ret_d   = IDLE;
            state_d = GAP;
         end
         GAP:     state_d = ret_q;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q  <= IDLE;
         ret_q    <= IDLE;
         arm_q    <= 1'b0;
         wr_q     <= 1'b0;
         multi_q  <= 1'b0;
         rsp_q    <= 8'h00;
         rdat_q   <= 16'h0000;
         tx_dat_o <= 8'h00;
         tx_stb_o <= 1'b0;
         wb_adr_o <= 16'h0000;
         wb_dat_o <= 16'h0000;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         arm_q    <= 1'b1;
         tx_stb_o <= tx_fire;
         if (tx_fire) tx_dat_o <= tx_byte;
         if (rx_ok) begin
            case (state_q)
               IDLE: begin
                  wr_q <= (rx_dat_i == CMD_WR);
                  if (!is_cmd) begin
                     rsp_q   <= RSP_BAD;
                     multi_q <= 1'b0;
                  end
               end
               ADRL:    wb_adr_o[7:0]  <= {rx_dat_i[7:1], 1'b0};
               ADRH:    wb_adr_o[15:8] <= rx_dat_i;
               DATL:    wb_dat_o[7:0]  <= rx_dat_i;
               DATH:    wb_dat_o[15:8] <= rx_dat_i;
               default: ;
            endcase
         end
         if (bus_start) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= wr_q;
         end
         if (bus_done || bus_tout) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
         end
         if (bus_done) begin
            rsp_q   <= RSP_OK;
            multi_q <= !wr_q;
            if (!wr_q) rdat_q <= wb_dat_i;
         end
         if (bus_tout) begin
            rsp_q   <= RSP_TO;
            multi_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wbm_serial_bridge.sv
// Scoreboard bench for wbm_serial_bridge: expected tx bytes and bus cycles are queued
// when commands are sent and checked as the bridge produces them.
module tb_wbm_serial_bridge;
   localparam int TOUT_T = 8;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [7:0]  rx_dat = 8'h00;
   logic        rx_stb = 1'b0;
   logic [7:0]  tx_dat_o;
   logic        tx_stb_o;
   logic        tx_rdy = 1'b1;
   logic [15:0] wb_adr_o, wb_dat_o;
   logic [15:0] wb_dat_i = 16'h0000;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic        wb_ack_i = 1'b0;
   logic        busy_o;

   wbm_serial_bridge #(.TOUT(TOUT_T)) dut (
      .wb_clk_i (clk),
      .wb_rstn_i(rstn),
      .rx_dat_i (rx_dat),
      .rx_stb_i (rx_stb),
      .tx_dat_o (tx_dat_o),
      .tx_stb_o (tx_stb_o),
      .tx_rdy_i (tx_rdy),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_ack_i (wb_ack_i),
      .busy_o   (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] adr;
      logic        we;
      logic [15:0] dat;
   } bus_t;

   bus_t       exp_bus[$];
   logic [7:0] exp_tx[$];
   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // tx monitor
   int tx_cnt   = 0;
   int since_tx = 100;
   always @(negedge clk) begin
      since_tx++;
      if (tx_stb_o) begin
         tx_cnt++;
         check_eq("tx_space", 32'(since_tx >= 2), 32'd1);
         since_tx = 0;
         check_eq("tx_pending", 32'(exp_tx.size() != 0), 32'd1);
         if (exp_tx.size() != 0) check_eq("tx_byte", {24'h0, tx_dat_o}, {24'h0, exp_tx.pop_front()});
      end
   end

   // Wishbone slave model
   int          ack_delay = 1;
   int          cyc_cnt = 0;
   int          last_cyc_len = 0;
   int          we_cyc = 0;
   logic [15:0] rd_data = 16'h0000;
   logic [15:0] cur_adr = 16'h0000;
   always @(negedge clk) begin
      if (wb_cyc_o) begin
         cyc_cnt++;
         if (wb_we_o) we_cyc++;
         if (cyc_cnt == 1) begin
            cur_adr = wb_adr_o;
            check_eq("bus_pending", 32'(exp_bus.size() != 0), 32'd1);
            check_eq("bus_stb", {31'h0, wb_stb_o}, 32'd1);
            if (exp_bus.size() != 0) begin
               bus_t e;
               e = exp_bus.pop_front();
               check_eq("bus_adr", {16'h0, wb_adr_o}, {16'h0, e.adr});
               check_eq("bus_we", {31'h0, wb_we_o}, {31'h0, e.we});
               if (e.we) check_eq("bus_dat", {16'h0, wb_dat_o}, {16'h0, e.dat});
            end
         end
         wb_dat_i = rd_data;
         wb_ack_i = (cyc_cnt == ack_delay);
         if (wb_ack_i) check_eq("adr_hold", {16'h0, wb_adr_o}, {16'h0, cur_adr});
      end else begin
         if (cyc_cnt != 0) last_cyc_len = cyc_cnt;
         cyc_cnt  = 0;
         wb_ack_i = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_dat = b;
      rx_stb = 1'b1;
      @(negedge clk);
      rx_stb = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [15:0] adr, input logic [15:0] data, input int dly);
      bus_t e;
      e.adr = adr; e.we = 1'b0; e.dat = 16'h0000;
      exp_bus.push_back(e);
      exp_tx.push_back(8'h2B);
      exp_tx.push_back(data[7:0]);
      exp_tx.push_back(data[15:8]);
      rd_data   = data;
      ack_delay = dly;
      send_byte(8'h52);
      send_byte(adr[7:0]);
      send_byte(adr[15:8]);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300 && (busy_o || exp_tx.size() != 0); i++) @(negedge clk);
      check_eq({tag, "_idle"}, {31'h0, busy_o}, 32'd0);
      check_eq({tag, "_txq"}, 32'(exp_tx.size()), 32'd0);
   endtask

   initial begin
      int t0;
      bus_t e;
      #1 rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_cyc", {31'h0, wb_cyc_o}, 32'd0);
      check_eq("rst_stb", {29'h0, wb_stb_o, wb_we_o, tx_stb_o}, 32'd0);
      check_eq("rst_busy", {31'h0, busy_o}, 32'd0);
      check_eq("rst_adr", {wb_adr_o, wb_dat_o}, 32'd0);
      check_eq("rst_txd", {24'h0, tx_dat_o}, 32'd0);

      // strobe already high on the first edge after release must be ignored
      rx_dat = 8'h00;
      rx_stb = 1'b1;
      #2 rstn = 1'b1;
      @(negedge clk);
      rx_stb = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("rel_busy", {31'h0, busy_o}, 32'd0);
      check_eq("rel_tx", 32'(tx_cnt), 32'd0);

      // read
      do_read(16'hFF10, 16'hBEEF, 3);
      wait_idle("read");
      check_eq("read_len", 32'(last_cyc_len), 32'd3);

      // write with odd address byte
      e.adr = 16'hFF64; e.we = 1'b1; e.dat = 16'h0041;
      exp_bus.push_back(e);
      exp_tx.push_back(8'h2B);
      ack_delay = 1;
      we_cyc = 0;
      send_byte(8'h57);
      send_byte(8'h65);
      send_byte(8'hFF);
      send_byte(8'h41);
      send_byte(8'h00);
      wait_idle("write");
      check_eq("write_we_cyc", 32'(we_cyc), 32'd1);

      // illegal command, byte during RSP0 dropped
      t0 = tx_cnt;
      tx_rdy = 1'b0;
      exp_tx.push_back(8'h3F);
      send_byte(8'h00);
      check_eq("ill_busy", {31'h0, busy_o}, 32'd1);
      send_byte(8'h52);
      repeat (3) @(negedge clk);
      tx_rdy = 1'b1;
      wait_idle("illegal");
      check_eq("ill_tx_cnt", 32'(tx_cnt - t0), 32'd1);
      repeat (10) @(negedge clk);
      check_eq("ill_nobus", {31'h0, busy_o}, 32'd0);

      // transmitter back-pressure
      tx_rdy = 1'b0;
      t0 = tx_cnt;
      do_read(16'h0020, 16'h1234, 2);
      repeat (50) @(negedge clk);
      check_eq("rdy_hold", 32'(tx_cnt - t0), 32'd0);
      check_eq("rdy_busy", {31'h0, busy_o}, 32'd1);
      tx_rdy = 1'b1;
      wait_idle("rdy");
      check_eq("rdy_tx_cnt", 32'(tx_cnt - t0), 32'd3);

      // unacknowledged bus cycle
      e.adr = 16'h0200; e.we = 1'b0; e.dat = 16'h0000;
      exp_bus.push_back(e);
      ack_delay = -1;
`ifdef WBM_SERIAL_TIMEOUT_EN
      exp_tx.push_back(8'h21);
      rd_data = 16'hDEAD;
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h02);
      wait_idle("tout");
      check_eq("tout_len", 32'(last_cyc_len), 32'(TOUT_T));
`else
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h02);
      repeat (1000) @(negedge clk);
      check_eq("nto_cyc", {31'h0, wb_cyc_o}, 32'd1);
      check_eq("nto_len", 32'(cyc_cnt >= 999), 32'd1);
      rd_data = 16'h5A17;
      exp_tx.push_back(8'h2B);
      exp_tx.push_back(8'h17);
      exp_tx.push_back(8'h5A);
      ack_delay = cyc_cnt + 2;
      wait_idle("nto");
`endif

      // reset in the middle of a bus cycle
      ack_delay = -1;
      e.adr = 16'h0300; e.we = 1'b0; e.dat = 16'h0000;
      exp_bus.push_back(e);
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h03);
      for (int i = 0; i < 20 && !wb_cyc_o; i++) @(negedge clk);
      check_eq("mrst_cyc_up", {31'h0, wb_cyc_o}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      check_eq("mrst_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'd0);
      check_eq("mrst_busy", {31'h0, busy_o}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      t0 = tx_cnt;
      repeat (20) @(negedge clk);
      check_eq("mrst_tx", 32'(tx_cnt - t0), 32'd0);
      check_eq("mrst_idle", {31'h0, busy_o}, 32'd0);

      do_read(16'h0100, 16'hA55A, 2);
      wait_idle("post_rst");
      check_eq("bus_q_empty", 32'(exp_bus.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/wbm_serial_bridge.md
WBM_SERIAL_BRIDGE -- requirements
Module: wbm_serial_bridge

Interface
REQ-001 SHALL have parameter TOUT, default 255, bus-timeout limit in clock cycles (1..65535).
REQ-002 SHALL have port wb_clk_i, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rstn_i, input, 1, reset: asynchronous assertion, active-low.
REQ-004 SHALL have port rx_dat_i, input, 8, received serial byte.
REQ-005 SHALL have port rx_stb_i, input, 1, one-cycle strobe qualifying rx_dat_i.
REQ-006 SHALL have port tx_dat_o, output, 8, response byte to the transmitter.
REQ-007 SHALL have port tx_stb_o, output, 1, one-cycle strobe qualifying tx_dat_o.
REQ-008 SHALL have port tx_rdy_i, input, 1, transmitter can accept a byte.
REQ-009 SHALL have port wb_adr_o, output, 16, Wishbone master byte address.
REQ-010 SHALL have ports wb_dat_o, output, 16 (write data), and wb_dat_i, input, 16 (read data).
REQ-011 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o, outputs, 1 each, and wb_ack_i, input, 1.
REQ-012 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, ADRL, ADRH, DATL, DATH, BUS, RSP0, RSP1, RSP2, GAP.
REQ-014 SHALL act only on bytes with rx_stb_i=1, and only in IDLE, ADRL, ADRH, DATL or DATH.
REQ-015 SHALL silently drop bytes arriving in BUS, RSPx or GAP.
REQ-016 SHALL handle command bytes in IDLE as follows:
- 0x52 ('R'): clear write flag, go to ADRL.
- 0x57 ('W'): set write flag, go to ADRL.
- Any other value: queue reply 0x3F ('?') and go to RSP0.
REQ-017 SHALL take the address low byte in ADRL and the high byte in ADRH, and force address bit 0 to 0.
REQ-018 SHALL go from ADRH to DATL for a write and to BUS for a read.
REQ-019 SHALL take the data low byte in DATL and the high byte in DATH, then go to BUS.
REQ-020 SHALL raise wb_cyc_o and wb_stb_o on the cycle after entering BUS, with wb_we_o equal to the write flag.
REQ-021 SHALL hold wb_adr_o and wb_dat_o stable while wb_cyc_o=1.
REQ-022 SHALL, on the first cycle with wb_ack_i=1 in BUS:
- drop wb_cyc_o, wb_stb_o and wb_we_o on the next edge;
- capture wb_dat_i for a read;
- go to RSP0.
REQ-023 SHALL ignore wb_ack_i while wb_cyc_o=0.
REQ-024 SHALL send the following responses:
- Read: 0x2B ('+'), then data low byte, then data high byte.
- Write: 0x2B only.
- Error: a single byte (0x3F or 0x21).
REQ-025 SHALL emit each response byte in RSPn as a one-cycle tx_stb_o pulse, only on a cycle where tx_rdy_i=1.
REQ-026 SHALL pass through GAP for exactly one cycle after each pulse, ignoring tx_rdy_i there.
REQ-027 SHALL return to IDLE after the last response byte's GAP cycle.
REQ-028 SHALL give IDLE-state command decoding priority, so a byte strobed in the cycle GAP exits to IDLE is dropped.
REQ-029 SHALL add no inter-byte timeout; a partial command waits indefinitely.

Reset
REQ-030 SHALL, while wb_rstn_i=0, hold the following values, independent of the clock:
- state IDLE;
- wb_cyc_o, wb_stb_o, wb_we_o, tx_stb_o, busy_o at 0;
- wb_adr_o, wb_dat_o, tx_dat_o and the captured data at 0x0000/0x00.
REQ-031 SHALL, if reset is asserted mid-bus-cycle, drop wb_cyc_o immediately and send no response after release.
REQ-032 SHALL NOT act on the first rising edge after deassertion if rx_stb_i is already high then.

Configuration
REQ-033 SHALL, with WBM_SERIAL_TIMEOUT_EN defined, time out bus cycles:
- A 16-bit counter clears on entry to BUS and increments each BUS cycle.
- At TOUT cycles without ack, it drops wb_cyc_o and wb_stb_o.
- It replies the single byte 0x21 ('!') and discards the read data.
REQ-034 SHALL, without WBM_SERIAL_TIMEOUT_EN, have no counter and wait for wb_ack_i indefinitely.
REQ-035 SHALL treat an ack arriving on the same cycle as the timeout as a normal completion.

Verification
REQ-036 Read: bytes 52 10 FF, ack after 3 cycles with wb_dat_i=0xBEEF -> wb_adr_o=0xFF10 with we=0; then tx 2B EF BE.
REQ-037 Write: bytes 57 65 FF 41 00, ack next cycle -> one cycle with we=1, adr 0xFF64 (bit0 cleared), dat 0x0041; then tx 2B.
REQ-038 Illegal command 0x00 -> tx 3F and no Wishbone cycle; a byte strobed during RSP0 is dropped.
REQ-039 tx_rdy_i held low 50 cycles during a read response -> no tx_stb_o until it rises, and pulses spaced at least 2 cycles apart.
REQ-040 With WBM_SERIAL_TIMEOUT_EN and TOUT=8, no ack -> cyc drops after 8 cycles and tx 21; without the macro, cyc stays high for 1000 cycles.
REQ-041 wb_rstn_i pulsed low during BUS -> wb_cyc_o low asynchronously, no tx_stb_o, and the next 'R' command works normally.
